// File: rtl/dffs_preset_sequencer.sv
// Preset/load sequencer for a bank of set-able flops: synchronizes a preset
// request into a minimum-width SN pulse, enforces recovery, then gates loads.
module dffs_preset_sequencer #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ASSERT_CYC  = 4,
   parameter int RECOVER_CYC = 2
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             PRESET_REQ,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             SN,
   output logic [WIDTH-1:0] D,
   output logic             LOAD,
   output logic             BUSY
);

   localparam int MAX_CYC = (ASSERT_CYC > RECOVER_CYC) ? ASSERT_CYC : RECOVER_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] ASSERT_LAST  = CW'(ASSERT_CYC - 1);
   localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYC - 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t                 state_r;
   logic [CW-1:0]          cnt_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sn_r;
   logic [WIDTH-1:0]       d_r;
   logic                   load_r;
   logic                   busy_r;
   logic                   req_s;
   logic                   xfer_s;

   assign req_s    = sync_r[SYNC_STAGES-1];
   assign IN_READY = (state_r == ST_RUN) && !req_s;
   assign xfer_s   = IN_VALID && IN_READY;

   assign SN   = sn_r;
   assign D    = d_r;
   assign LOAD = load_r;
   assign BUSY = busy_r;

   // Request synchronizer, sequencing FSM and all registered bank-side outputs.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_r <= ST_ASSERT;
         cnt_r   <= CNT_ZERO;
         sync_r  <= {SYNC_STAGES{1'b0}};
         sn_r    <= 1'b0;
         d_r     <= ALL_ONES;
         load_r  <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], PRESET_REQ};
         load_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               if (req_s) begin
                  state_r <= ST_ASSERT;
                  cnt_r   <= CNT_ZERO;
                  sn_r    <= 1'b0;
                  d_r     <= ALL_ONES;
                  busy_r  <= 1'b1;
               end else if (xfer_s) begin
                  d_r    <= IN_DATA;
                  load_r <= 1'b1;
               end else begin
                  d_r <= d_r;
               end
            end
            ST_ASSERT: begin
               d_r <= ALL_ONES;
               // D is already all ones here, so SN rises with D stable.
               if (cnt_r == ASSERT_LAST) begin
                  if (!req_s) begin
                     state_r <= ST_RECOVER;
                     cnt_r   <= CNT_ZERO;
                     sn_r    <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_RECOVER: begin
               if (req_s) begin
                  state_r <= ST_ASSERT;
                  cnt_r   <= CNT_ZERO;
                  sn_r    <= 1'b0;
               end else if (cnt_r == RECOVER_LAST) begin
                  state_r <= ST_RUN;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_ASSERT;
               cnt_r   <= CNT_ZERO;
               sn_r    <= 1'b0;
               d_r     <= ALL_ONES;
               busy_r  <= 1'b1;
            end
         endcase
      end
   end

   dffs_preset_sequencer_chk #(.WIDTH(WIDTH)) u_chk (
      .CK   (CK),
      .RST  (RST),
      .SN   (SN),
      .D    (D),
      .LOAD (LOAD),
      .BUSY (BUSY)
   );

endmodule

// Checker for bank-side invariants of the preset sequencer.
module dffs_preset_sequencer_chk #(
   parameter int WIDTH = 8
) (
   input logic             CK,
   input logic             RST,
   input logic             SN,
   input logic [WIDTH-1:0] D,
   input logic             LOAD,
   input logic             BUSY
);

   a_d_stable_on_sn_rise: assert property (@(posedge CK) disable iff (RST)
      $rose(SN) |-> $stable(D));

   a_load_only_in_run: assert property (@(posedge CK) disable iff (RST)
      LOAD |-> (SN && !BUSY));

endmodule

// File: doc/dffs_preset_sequencer.md
Name: dffs_preset_sequencer

Overview:
- Control stage directly upstream of a bank of set-able flip-flops: clock `CK`, active-low asynchronous preset `SN`, data `D`.
- Turns an asynchronous preset request into a clean, synchronous active-low `SN` pulse.
  - `SN` low time is guaranteed to be at least a minimum width.
  - A recovery gap is enforced before any new data is captured.
- Feeds `D`, plus a one-cycle `LOAD` strobe, to the bank through a valid/ready input handshake.

Parameters:
- `WIDTH`, 8: data width of the downstream flop bank.
- `SYNC_STAGES`, 2: synchronizer depth on `PRESET_REQ`; legal range ≥ 2.
- `ASSERT_CYC`, 4: minimum number of cycles `SN` is held low; legal range ≥ 1.
- `RECOVER_CYC`, 2: cycles after `SN` rises during which no load is issued; legal range ≥ 1.

Ports:
- `CK`, input, 1: sole clock, rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `PRESET_REQ`, input, 1: asynchronous level request to preset the bank.
- `IN_VALID`, input, 1: upstream data valid.
- `IN_READY`, output, 1: block accepts data this cycle.
- `IN_DATA`, input, `WIDTH`: upstream data.
- `SN`, output, 1: active-low preset to the bank; registered.
- `D`, output, `WIDTH`: data to the bank; registered.
- `LOAD`, output, 1: one-cycle capture strobe / clock enable to the bank; registered.
- `BUSY`, output, 1: high whenever the state is not RUN.

Behaviour:
- Clocking: one clock `CK`; reset `RST` is synchronous and active-high.
- Reset values, at the first rising `CK` with `RST`=1:
  - state = ASSERT, counter = 0, all synchronizer flops = 0.
  - `SN`=0, `D`=all ones, `LOAD`=0, `BUSY`=1, `IN_READY`=0.
  - Reset therefore presets the bank.
- Synchronizer: `PRESET_REQ` passes through `SYNC_STAGES` flops; `req_s` is the last stage. Latency from `PRESET_REQ` to `req_s` is `SYNC_STAGES` cycles.
- `IN_READY` is combinational: (state==RUN) && !`req_s`.
- A transfer occurs when `IN_VALID` && `IN_READY` are both high on a rising `CK`.
- State RUN:
  - `SN`=1.
  - On a transfer: `D` <= `IN_DATA` and `LOAD` <= 1 for exactly one cycle. Otherwise `LOAD` <= 0 and `D` holds.
  - If `req_s`=1: next state is ASSERT, counter <= 0, `SN` <= 0, `D` <= all ones, `LOAD` <= 0.
  - A preset request always wins over a same-cycle transfer, because `IN_READY` is already 0.
- State ASSERT:
  - `SN`=0, `D`=all ones, `LOAD`=0.
  - Counter increments each cycle and saturates at `ASSERT_CYC`-1.
  - Exits to RECOVER when counter == `ASSERT_CYC`-1 and `req_s`=0. `SN` <= 1 and counter <= 0 on that edge.
  - While `req_s` stays high, the block remains in ASSERT indefinitely.
  - `SN` low time is therefore ≥ `ASSERT_CYC` cycles, and equals exactly `ASSERT_CYC` when no request is pending.
- State RECOVER:
  - `SN`=1, `LOAD`=0, `D` holds all ones.
  - Counter increments each cycle; moves to RUN when counter == `RECOVER_CYC`-1.
  - If `req_s`=1 in RECOVER: return to ASSERT, counter <= 0, `SN` <= 0. The full `ASSERT_CYC` minimum applies again.
- `BUSY` is registered alongside the state and equals (state != RUN).
- Counter width: clog2 of max(`ASSERT_CYC`, `RECOVER_CYC`), minimum 1 bit. The counter never wraps.
- `RST` asserted mid-operation, in any state: the reset values above take effect on the next edge.
  - A pending `LOAD` is cancelled.
  - `IN_DATA` presented in that cycle is not accepted.
- `D` never changes in a cycle where `SN` makes a 0→1 transition. This preserves the bank's recovery margin.
- Idle `IN_VALID` with `IN_READY`=1: no state change, `LOAD` stays 0.

Test Plan:
- Reset release (defaults):
  - Stimulus: hold `RST`=1 for 3 cycles, release at edge 0, `PRESET_REQ`=0.
  - Required: `SN`=0 through edge 3 and rises at edge 4; `BUSY`=1 through edge 5; `IN_READY`=1 from the cycle after edge 6; `D`=0xFF throughout.
- Single load:
  - Stimulus: in RUN, `IN_VALID`=1 with `IN_DATA`=0x5A for one cycle.
  - Required: `D`=0x5A and `LOAD`=1 for exactly one cycle after the edge; `LOAD`=0 next cycle; `D` holds 0x5A.
- Short preset request:
  - Stimulus: 1-cycle `PRESET_REQ` pulse while in RUN with `D`=0x5A.
  - Required: `IN_READY` drops 2 cycles later (`SYNC_STAGES`=2); `SN` low for exactly 4 cycles; `D`=0xFF; 2 RECOVER cycles, then `IN_READY`=1.
- Long preset request:
  - Stimulus: `PRESET_REQ` held high for 10 cycles.
  - Required: `SN` stays 0 until 1 cycle after `req_s` falls (≥10 cycles low); no `LOAD` strobe occurs.
- Re-request during RECOVER:
  - Stimulus: `PRESET_REQ` re-asserted so that `req_s` rises in the first RECOVER cycle.
  - Required: `SN` returns to 0 for a fresh full 4 cycles; `BUSY` stays 1 throughout.
- Collision and mid-operation reset:
  - Stimulus: `IN_VALID`=1 in the same cycle `req_s` rises; separately, `RST` pulsed during RUN while a transfer is presented.
  - Required: no transfer and no `LOAD` in either case; `SN`=0 and `D`=0xFF on the next edge.
